// File: rtl/calc_display.sv
// Calculator display stage: double-dabble binary-to-BCD converter plus 8-digit 7-segment scan.
// Optional build macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module calc_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [27:0] value,
    input  logic        sign,
    input  logic        overflow,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        neg_led,
    output logic        busy,
    output logic [31:0] disp_bcd
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state, state_next;
    logic [29:0] snap;
    logic [29:0] cur;
    logic [27:0] sreg;
    logic [35:0] work;
    logic [35:0] work_adj;
    logic [4:0]  bit_cnt;
    logic        disp_ovf;
    logic        disp_sign;

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic [3:0]    nib_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = GLYPH_BLANK;
        endcase
    endfunction

    assign cur = {overflow, sign, value};

    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cur != snap) state_next = SHIFT;
            SHIFT:   if (bit_cnt == 5'd27) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        work_adj = work;
        for (int unsigned i = 0; i < 9; i++) begin
            if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            snap      <= '0;
            sreg      <= '0;
            work      <= '0;
            bit_cnt   <= '0;
            disp_bcd  <= '0;
            disp_ovf  <= 1'b0;
            disp_sign <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cur != snap) begin
                        snap    <= cur;
                        sreg    <= value;
                        work    <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {work, sreg} <= {work_adj, sreg} << 1;
                    bit_cnt      <= bit_cnt + 5'd1;
                end
                COMMIT: begin
                    disp_bcd  <= work[31:0];
                    // a ninth BCD digit means the value exceeds eight display digits
                    disp_ovf  <= snap[29] | (work[35:32] != 4'd0);
                    disp_sign <= snap[28];
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign neg_led = disp_sign & ~disp_ovf & (disp_bcd != 32'd0);

    assign idx_next = (presc == PRESC_LAST) ? idx + 3'd1 : idx;
    assign nib_next = disp_bcd[{idx_next, 2'b00} +: 4];

`ifdef LEAD_ZERO_BLANK_EN
    logic [2:0] msd;

    always_comb begin
        msd = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (disp_bcd[4*i +: 4] != 4'd0) msd = 3'(i);
        end
    end

    always_comb begin
        seg_next = glyph(nib_next);
        if (disp_ovf)             seg_next = (idx_next == 3'd0) ? GLYPH_E : GLYPH_BLANK;
        else if (idx_next > msd)  seg_next = GLYPH_BLANK;
    end
`else
    always_comb begin
        seg_next = glyph(nib_next);
        if (disp_ovf) seg_next = (idx_next == 3'd0) ? GLYPH_E : GLYPH_BLANK;
    end
`endif

    // seg and an are both registered from the upcoming index so they switch together
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            an    <= 8'b11111110;
            seg   <= 7'b1000000;
        end else begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
            idx   <= idx_next;
            an    <= ~(8'b1 << idx_next);
            seg   <= seg_next;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// Directed self-checking bench for calc_display (SCAN_DIV=4); honours LEAD_ZERO_BLANK_EN if defined.
module tb_calc_display;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] GE = 7'b0000110;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [27:0] value;
    logic        sign;
    logic        overflow;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        neg_led;
    logic        busy;
    logic [31:0] disp_bcd;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] exp_seg [8];

    calc_display #(.SCAN_DIV(4)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .value    (value),
        .sign     (sign),
        .overflow (overflow),
        .seg      (seg),
        .an       (an),
        .neg_led  (neg_led),
        .busy     (busy),
        .disp_bcd (disp_bcd)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Inputs must already differ from the snapshot; next edge captures them.
    task automatic run_conv(input string tag, input logic [31:0] exp_bcd);
        tick();
        chk({tag, "_busy_start"}, 32'(busy), 32'd1);
        repeat (28) tick();
        chk({tag, "_busy_last"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_bcd"}, disp_bcd, exp_bcd);
    endtask

    task automatic scan_check(input string tag);
        logic [7:0] prev;
        int idx;
        int waited;
        prev = an;
        waited = 0;
        while (an === prev && waited < 8) begin
            tick();
            waited++;
        end
        chk({tag, "_sync"}, 32'(an !== prev), 32'd1);
        for (int s = 0; s < 8; s++) begin
            idx = 0;
            for (int b = 0; b < 8; b++) if (an[b] === 1'b0) idx = b;
            chk({tag, "_an_onehot"}, 32'($countones(~an)), 32'd1);
            chk($sformatf("%s_seg_d%0d", tag, idx), 32'(seg), 32'(exp_seg[idx]));
            prev = an;
            repeat (3) tick();
            chk({tag, "_an_hold"}, 32'(an), 32'(prev));
            tick();
            chk({tag, "_an_step"}, 32'(an), 32'({prev[6:0], prev[7]}));
        end
    endtask

    initial begin
        rst = 1'b1; value = 28'd1234; sign = 1'b0; overflow = 1'b0;
        repeat (2) tick();
        chk("rst_seg", 32'(seg), 32'(G0));
        chk("rst_an", 32'(an), 32'h000000FE);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bcd", disp_bcd, 32'd0);
        chk("rst_neg", 32'(neg_led), 32'd0);

        rst = 1'b0;
        run_conv("v1234", 32'h00001234);
        chk("v1234_neg", 32'(neg_led), 32'd0);

        value = 28'd99980001; sign = 1'b1;
        run_conv("v9998", 32'h99980001);
        chk("v9998_neg", 32'(neg_led), 32'd1);

        value = 28'd0; sign = 1'b1;
        run_conv("negzero", 32'h00000000);
        chk("negzero_neg", 32'(neg_led), 32'd0);

        value = 28'd100000000; sign = 1'b1;
        run_conv("big", 32'h00000000);
        chk("big_neg", 32'(neg_led), 32'd0);
        exp_seg[0] = GE;
        for (int i = 1; i < 8; i++) exp_seg[i] = GB;
        scan_check("big_scan");

        overflow = 1'b1; value = 28'd5;
        run_conv("ovf", 32'h00000005);
        chk("ovf_neg", 32'(neg_led), 32'd0);
        scan_check("ovf_scan");

        overflow = 1'b0; sign = 1'b0; value = 28'd11;
        tick();
        chk("ovl_busy0", 32'(busy), 32'd1);
        repeat (9) tick();
        value = 28'd22;
        repeat (20) tick();
        chk("ovl_first_busy", 32'(busy), 32'd0);
        chk("ovl_first_bcd", disp_bcd, 32'h00000011);
        tick();
        chk("ovl_restart", 32'(busy), 32'd1);
        repeat (28) tick();
        chk("ovl_second_busy", 32'(busy), 32'd1);
        tick();
        chk("ovl_second_done", 32'(busy), 32'd0);
        chk("ovl_second_bcd", disp_bcd, 32'h00000022);

        value = 28'd407;
        run_conv("v407", 32'h00000407);
        exp_seg[0] = G7;
        exp_seg[1] = G0;
        exp_seg[2] = G4;
`ifdef LEAD_ZERO_BLANK_EN
        for (int i = 3; i < 8; i++) exp_seg[i] = GB;
`else
        for (int i = 3; i < 8; i++) exp_seg[i] = G0;
`endif
        scan_check("v407_scan");

        value = 28'd12345;
        tick();
        chk("abort_busy", 32'(busy), 32'd1);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy_after", 32'(busy), 32'd0);
        chk("abort_bcd", disp_bcd, 32'd0);
        chk("abort_an", 32'(an), 32'h000000FE);
        chk("abort_seg", 32'(seg), 32'(G0));
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
